// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard/control unit.
package hazard_pkg;

    // Memory-wait supervisor FSM encodings
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_FAULT    = 2'b10;

    // Operand forward selects as seen by the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ResultSrc value that identifies a load sitting in EX
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the hazard/control unit.
// The master side is the datapath, the slave side is hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int RESULTSRC_WIDTH = 2,
    parameter int CNT_WIDTH       = 32
);
    logic [REG_ADDR_WIDTH-1:0]  rs1_D;
    logic [REG_ADDR_WIDTH-1:0]  rs2_D;
    logic [REG_ADDR_WIDTH-1:0]  rs1_E;
    logic [REG_ADDR_WIDTH-1:0]  rs2_E;
    logic [REG_ADDR_WIDTH-1:0]  rd_E;
    logic [REG_ADDR_WIDTH-1:0]  rd_M;
    logic [REG_ADDR_WIDTH-1:0]  rd_W;
    logic [RESULTSRC_WIDTH-1:0] ResultSrc_E;
    logic                       RegWrite_M;
    logic                       RegWrite_W;
    logic                       PCSrc_E;
    logic                       mem_req_M;
    logic                       mem_ready_M;

    logic                       Stall_F;
    logic                       Stall_D;
    logic                       Stall_E;
    logic                       Stall_M;
    logic                       Flush_D;
    logic                       Flush_E;
    logic                       Flush_W;
    logic [1:0]                 ForwardA_E;
    logic [1:0]                 ForwardB_E;
    logic                       mem_timeout;
    logic [CNT_WIDTH-1:0]       stall_cnt;
    logic [CNT_WIDTH-1:0]       flush_cnt;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
               ResultSrc_E, RegWrite_M, RegWrite_W, PCSrc_E,
               mem_req_M, mem_ready_M,
        input  Stall_F, Stall_D, Stall_E, Stall_M,
               Flush_D, Flush_E, Flush_W,
               ForwardA_E, ForwardB_E,
               mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
               ResultSrc_E, RegWrite_M, RegWrite_W, PCSrc_E,
               mem_req_M, mem_ready_M,
        output Stall_F, Stall_D, Stall_E, Stall_M,
               Flush_D, Flush_E, Flush_W,
               ForwardA_E, ForwardB_E,
               mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding comparator for one EX-stage source operand.
// The younger MEM-stage result wins over the WB-stage result; x0 is never forwarded.
module hazard_fwd_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_E,
    input  logic [REG_ADDR_WIDTH-1:0] rd_M,
    input  logic [REG_ADDR_WIDTH-1:0] rd_W,
    input  logic                      RegWrite_M,
    input  logic                      RegWrite_W,
    output logic [1:0]                fwd_sel
);
    import hazard_pkg::*;

    // Pick the newest in-flight producer of rs_E, falling back to the register file
    always_comb begin
        fwd_sel = FWD_RF;
        if (RegWrite_M && (rd_M != '0) && (rd_M == rs_E)) begin
            fwd_sel = FWD_MEM;
        end else if (RegWrite_W && (rd_W != '0) && (rd_W == rs_E)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard and pipeline-control unit for the 5-stage core: forwarding,
// load-use interlock, redirect flushing and data-memory wait supervision.
module hazard_ctrl #(
    parameter int                         REG_ADDR_WIDTH  = 5,
    parameter int                         RESULTSRC_WIDTH = 2,
    parameter logic [RESULTSRC_WIDTH-1:0] RESULTSRC_LOAD  = RESULTSRC_WIDTH'(hazard_pkg::RESULTSRC_LOAD),
    parameter int                         MEM_TIMEOUT     = 64,
    parameter int                         CNT_WIDTH       = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    import hazard_pkg::*;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [1:0]           state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;

    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall, mem_stall, redirect;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;

    hazard_fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs_E       (hif.rs1_E),
        .rd_M       (hif.rd_M),
        .rd_W       (hif.rd_W),
        .RegWrite_M (hif.RegWrite_M),
        .RegWrite_W (hif.RegWrite_W),
        .fwd_sel    (fwd_a)
    );

    hazard_fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs_E       (hif.rs2_E),
        .rd_M       (hif.rd_M),
        .rd_W       (hif.rd_W),
        .RegWrite_M (hif.RegWrite_M),
        .RegWrite_W (hif.RegWrite_W),
        .fwd_sel    (fwd_b)
    );

    // Hazard detection; the memory stall is combinational so the first wait cycle freezes immediately
    always_comb begin
        lw_stall  = (hif.ResultSrc_E == RESULTSRC_LOAD) && (hif.rd_E != '0) &&
                    ((hif.rd_E == hif.rs1_D) || (hif.rd_E == hif.rs2_D));
        mem_stall = ((state_q == ST_RUN)      && hif.mem_req_M && !hif.mem_ready_M) ||
                    ((state_q == ST_MEM_WAIT) && !hif.mem_ready_M) ||
                    (state_q == ST_FAULT);
    end

    // Prioritised stall/flush generation: reset, memory freeze, redirect, load-use
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        redirect = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            // A redirect held in the frozen EX stage is serviced once the freeze lifts
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hif.PCSrc_E) begin
            // The load-use dependent sits in ID and is flushed anyway, so no interlock
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            redirect = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Memory-wait supervisor: RUN -> MEM_WAIT on an unfinished access, FAULT on timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (hif.mem_req_M && !hif.mem_ready_M) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (hif.mem_ready_M) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        mem_timeout_d = (state_d == ST_FAULT);
    end

    // Saturating performance counters for stalled cycles and redirect flushes
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State, wait counter, fault flag and counters, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hif.Stall_F     = stall_f;
    assign hif.Stall_D     = stall_d;
    assign hif.Stall_E     = stall_e;
    assign hif.Stall_M     = stall_m;
    assign hif.Flush_D     = flush_d;
    assign hif.Flush_E     = flush_e;
    assign hif.Flush_W     = flush_w;
    assign hif.ForwardA_E  = rst ? FWD_RF : fwd_a;
    assign hif.ForwardB_E  = rst ? FWD_RF : fwd_b;
    assign hif.mem_timeout = mem_timeout_q;
    assign hif.stall_cnt   = stall_cnt_q;
    assign hif.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a vector table for the combinational
// hazard logic plus hand-written sequences for memory wait, timeout and reset.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 64;

    // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
    localparam logic [6:0] CTRL_NONE     = 7'b0000000;
    localparam logic [6:0] CTRL_LWSTALL  = 7'b1100010;
    localparam logic [6:0] CTRL_REDIRECT = 7'b0000110;
    localparam logic [6:0] CTRL_MEM      = 7'b1111001;
    localparam logic [6:0] CTRL_RESET    = 7'b0000111;

    typedef struct {
        logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic [1:0] res_src;
        logic       rw_m, rw_w, pcsrc, req, ready;
        logic [1:0] exp_fa, exp_fb;
        logic [6:0] exp_ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_count  = 0;
    int   miscompares = 0;
    vec_t vecs [16];
    vec_t v;
    vec_t zero_v;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .RESULTSRC_WIDTH(2), .CNT_WIDTH(32)) hif ();

    hazard_ctrl #(
        .REG_ADDR_WIDTH  (5),
        .RESULTSRC_WIDTH (2),
        .RESULTSRC_LOAD  (2'b01),
        .MEM_TIMEOUT     (TIMEOUT),
        .CNT_WIDTH       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    function automatic logic [6:0] ctrlBits();
        return {hif.Stall_F, hif.Stall_D, hif.Stall_E, hif.Stall_M,
                hif.Flush_D, hif.Flush_E, hif.Flush_W};
    endfunction

    task automatic applyStimulus(input vec_t s);
        hif.rs1_D       = s.rs1_D;
        hif.rs2_D       = s.rs2_D;
        hif.rs1_E       = s.rs1_E;
        hif.rs2_E       = s.rs2_E;
        hif.rd_E        = s.rd_E;
        hif.rd_M        = s.rd_M;
        hif.rd_W        = s.rd_W;
        hif.ResultSrc_E = s.res_src;
        hif.RegWrite_M  = s.rw_m;
        hif.RegWrite_W  = s.rw_w;
        hif.PCSrc_E     = s.pcsrc;
        hif.mem_req_M   = s.req;
        hif.mem_ready_M = s.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle synchronous reset with checks of the forced outputs and cleared state
    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_ctrl"}, 32'(ctrlBits()), 32'(CTRL_RESET));
        checkOutput({tag, "_rst_fwd"}, 32'({hif.ForwardA_E, hif.ForwardB_E}), 32'd0);
        tick();
        checkOutput({tag, "_rst_timeout"}, 32'(hif.mem_timeout), 32'd0);
        checkOutput({tag, "_rst_stall_cnt"}, hif.stall_cnt, 32'd0);
        checkOutput({tag, "_rst_flush_cnt"}, hif.flush_cnt, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        zero_v = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        //          rs1_D  rs2_D  rs1_E  rs2_E  rd_E   rd_M   rd_W   res    rwm   rww   pc    req   rdy   fa     fb     ctrl
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, CTRL_NONE};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, CTRL_NONE};
        vecs[3]  = '{5'd0, 5'd0, 5'd6, 5'd7, 5'd0, 5'd6, 5'd7, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, CTRL_NONE};
        vecs[4]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        vecs[6]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, CTRL_NONE};
        vecs[7]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_LWSTALL};
        vecs[8]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_LWSTALL};
        vecs[9]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        vecs[11] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_REDIRECT};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_REDIRECT};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, CTRL_NONE};
        vecs[14] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE};
        vecs[15] = '{5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd3, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, CTRL_NONE};

        applyStimulus(zero_v);
        tick();
        $display("[TB] reset and vector table");
        doReset("init");

        // Combinational table in RUN: two load-use stalls (7, 8) and two redirects (11, 12)
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i),
                        32'({hif.ForwardA_E, hif.ForwardB_E, ctrlBits()}),
                        32'({vecs[i].exp_fa, vecs[i].exp_fb, vecs[i].exp_ctrl}));
            tick();
        end
        checkOutput("table_stall_cnt", hif.stall_cnt, 32'd2);
        checkOutput("table_flush_cnt", hif.flush_cnt, 32'd2);

        // Memory wait of 4 cycles with a redirect waiting in the frozen EX stage
        $display("[TB] memory wait sequence");
        doReset("memwait");
        v = zero_v;
        v.req = 1'b1;
        v.pcsrc = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) v.req = 1'b0;
            applyStimulus(v);
            #1;
            checkOutput($sformatf("memwait_c%0d", c), 32'(ctrlBits()), 32'(CTRL_MEM));
            tick();
        end
        v.ready = 1'b1;
        applyStimulus(v);
        #1;
        checkOutput("memwait_release", 32'(ctrlBits()), 32'(CTRL_REDIRECT));
        tick();
        applyStimulus(zero_v);
        #1;
        checkOutput("memwait_back_run", 32'(ctrlBits()), 32'(CTRL_NONE));
        checkOutput("memwait_stall_cnt", hif.stall_cnt, 32'd4);
        checkOutput("memwait_flush_cnt", hif.flush_cnt, 32'd1);
        tick();

        // Timeout: ready never arrives, FAULT after the last allowed wait cycle
        $display("[TB] timeout sequence");
        doReset("timeout");
        v = zero_v;
        v.req = 1'b1;
        applyStimulus(v);
        for (int e = 1; e <= TIMEOUT + 1; e++) begin
            tick();
            if (e == TIMEOUT) begin
                checkOutput("timeout_not_yet", 32'(hif.mem_timeout), 32'd0);
                checkOutput("timeout_stall_cnt_a", hif.stall_cnt, 32'(TIMEOUT));
            end
            if (e == TIMEOUT + 1) begin
                checkOutput("timeout_set", 32'(hif.mem_timeout), 32'd1);
            end
        end
        v.req = 1'b0;
        v.ready = 1'b1;
        applyStimulus(v);
        #1;
        checkOutput("fault_hold_ctrl", 32'(ctrlBits()), 32'(CTRL_MEM));
        for (int e = 0; e < 5; e++) tick();
        checkOutput("fault_sticky", 32'(hif.mem_timeout), 32'd1);
        checkOutput("timeout_stall_cnt_b", hif.stall_cnt, 32'(TIMEOUT + 6));
        v = zero_v;
        v.rs1_E = 5'd5;
        v.rd_M = 5'd5;
        v.rw_m = 1'b1;
        applyStimulus(v);
        doReset("fault");
        applyStimulus(zero_v);
        #1;
        checkOutput("fault_cleared_run", 32'(ctrlBits()), 32'(CTRL_NONE));
        tick();

        // Reset during the second MEM_WAIT cycle returns straight to RUN
        $display("[TB] reset mid-wait sequence");
        doReset("midwait_pre");
        v = zero_v;
        v.req = 1'b1;
        applyStimulus(v);
        tick();
        tick();
        v.rs1_E = 5'd5;
        v.rd_M = 5'd5;
        v.rw_m = 1'b1;
        applyStimulus(v);
        doReset("midwait");
        v = zero_v;
        v.rs1_E = 5'd5;
        v.rd_M = 5'd5;
        applyStimulus(v);
        #1;
        checkOutput("midwait_run_ctrl", 32'(ctrlBits()), 32'(CTRL_NONE));
        checkOutput("midwait_run_fwd", 32'({hif.ForwardA_E, hif.ForwardB_E}), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and pipeline-control unit for the 5-stage RISC-V core. It generates the stall, flush and forwarding controls that the IF/ID, ID/EX, EX/MEM and MEM/WB registers consume, including the Flush_E input of the ID/EX register. It resolves these hazards:
- load-use hazards;
- control redirects (taken branch or jump);
- multi-cycle data-memory waits, supervised by a small FSM with timeout and saturating performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register index width
RESULTSRC_WIDTH, 2, width of ResultSrc
RESULTSRC_LOAD, 2'b01, ResultSrc encoding that marks a load in EX
MEM_TIMEOUT, 64, maximum cycles in MEM_WAIT before fault
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
rs1_D  in  REG_ADDR_WIDTH  source register 1 in ID
rs2_D  in  REG_ADDR_WIDTH  source register 2 in ID
rs1_E  in  REG_ADDR_WIDTH  source register 1 in EX
rs2_E  in  REG_ADDR_WIDTH  source register 2 in EX
rd_E  in  REG_ADDR_WIDTH  destination register in EX
rd_M  in  REG_ADDR_WIDTH  destination register in MEM
rd_W  in  REG_ADDR_WIDTH  destination register in WB
ResultSrc_E  in  RESULTSRC_WIDTH  result select of the instruction in EX
RegWrite_M  in  1  MEM-stage instruction writes the register file
RegWrite_W  in  1  WB-stage instruction writes the register file
PCSrc_E  in  1  taken branch or jump resolved in EX
mem_req_M  in  1  data-memory access active in MEM
mem_ready_M  in  1  data memory completes the access this cycle
Stall_F  out  1  hold PC
Stall_D  out  1  hold IF/ID
Stall_E  out  1  hold ID/EX
Stall_M  out  1  hold EX/MEM
Flush_D  out  1  bubble IF/ID
Flush_E  out  1  bubble ID/EX
Flush_W  out  1  bubble MEM/WB
ForwardA_E  out  2  operand A forward select: 00 register file, 01 WB, 10 MEM
ForwardB_E  out  2  operand B forward select, same encoding
mem_timeout  out  1  sticky fault flag
stall_cnt  out  CNT_WIDTH  cycles with Stall_F asserted
flush_cnt  out  CNT_WIDTH  number of redirect flushes

Behaviour:
- Forwarding is combinational.
  - ForwardA_E = 10 if RegWrite_M && rd_M != 0 && rd_M == rs1_E.
  - Otherwise ForwardA_E = 01 if RegWrite_W && rd_W != 0 && rd_W == rs1_E.
  - Otherwise ForwardA_E = 00.
  - ForwardB_E is identical with rs2_E.
  - MEM has priority over WB.
- lwStall = (ResultSrc_E == RESULTSRC_LOAD) && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D).
- FSM states RUN, MEM_WAIT, FAULT; state is registered and updates on posedge clk.
  - RUN -> MEM_WAIT when mem_req_M && !mem_ready_M.
  - MEM_WAIT -> RUN when mem_ready_M.
  - MEM_WAIT -> FAULT when wait_cnt == MEM_TIMEOUT-1 && !mem_ready_M.
  - If mem_ready_M arrives in that same cycle, the transition is to RUN.
  - FAULT is left only by rst.
- wait_cnt:
  - clears on entry to MEM_WAIT;
  - increments each cycle while in MEM_WAIT;
  - its width is clog2(MEM_TIMEOUT)+1.
- memStall = (RUN && mem_req_M && !mem_ready_M) || (MEM_WAIT && !mem_ready_M) || FAULT. It is combinational, so there is zero-cycle latency on the first wait cycle.
- Control priority is per cycle, highest first.
  1. memStall: Stall_F = Stall_D = Stall_E = Stall_M = 1, Flush_W = 1, Flush_D = Flush_E = 0. A PCSrc_E held in a frozen EX is serviced on the release cycle.
  2. PCSrc_E: Flush_D = Flush_E = 1, all stalls 0. lwStall is ignored because the dependent instruction is being flushed.
  3. lwStall: Stall_F = Stall_D = 1, Flush_E = 1, others 0.
  4. Otherwise all stall and flush outputs are 0.
- mem_timeout is 1 in FAULT and registered.
- Counters:
  - stall_cnt increments on every cycle Stall_F == 1.
  - flush_cnt increments on every cycle the priority-2 redirect is taken.
  - Both saturate at all-ones.
- Reset, synchronous and sampled at posedge clk:
  - state = RUN, wait_cnt = 0, counters = 0, mem_timeout = 0.
  - While rst is high, combinational outputs are forced to Stall_* = 0, Flush_D = Flush_E = Flush_W = 1, Forward* = 00.
  - Reset asserted mid-MEM_WAIT or in FAULT returns the block to RUN on the next edge.

Decomposition:
- Shared package hazard_pkg holds:
  - the FSM state encodings;
  - the Forward encodings FWD_RF, FWD_WB, FWD_MEM;
  - RESULTSRC_LOAD.
- One sub-module, hazard_fwd_unit, holds the forwarding comparators, instanced once per operand.
- The FSM, counters and priority logic stay in hazard_ctrl.

Test Plan:
- EX-to-EX forwarding: rs1_E = 5, rd_M = 5, RegWrite_M = 1, and rd_W = 5, RegWrite_W = 1 -> ForwardA_E = 10. Repeat with rd_M = 0 -> ForwardA_E = 01.
- Load-use: ResultSrc_E = 01, rd_E = 3, rs2_D = 3 -> Stall_F = Stall_D = Flush_E = 1 for exactly 1 cycle, stall_cnt = 1.
- Branch vs load-use: PCSrc_E = 1 with lwStall true -> Flush_D = Flush_E = 1, Stall_F = 0, flush_cnt increments by 1.
- Memory wait: mem_req_M = 1, mem_ready_M low for 4 cycles -> all stalls held 4 cycles, FSM in MEM_WAIT for 3, Flush_W = 1, then RUN. A concurrent PCSrc_E flushes only on the release cycle.
- Timeout: mem_ready_M never rises -> mem_timeout = 1 after MEM_TIMEOUT wait cycles and stays 1. Asserting rst for 1 cycle clears it, with state RUN and counters 0.
- Reset mid-wait: rst asserted in MEM_WAIT cycle 2 -> next cycle state = RUN, Stall_* = 0, Forward* = 00.
